// File: rtl/cmd_issuer_if.sv
// cmd_issuer_if: command/response handshake plus UART tx/rx byte signals of cmd_issuer.
interface cmd_issuer_if #(
  parameter int unsigned MAX_BITS = 32
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [7:0]          cmd_op_i;
  logic [15:0]         cmd_count_i;
  logic [MAX_BITS-1:0] cmd_wdata_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [MAX_BITS-1:0] rsp_data_o;
  logic [15:0]         rsp_count_o;
  logic                rsp_err_o;
  logic                tx_start_o;
  logic [7:0]          tx_data_o;
  logic                tx_ready_i;
  logic [7:0]          rx_data_i;
  logic                new_rx_data_i;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_count_i, cmd_wdata_i, rsp_ready_i,
           tx_ready_i, rx_data_i, new_rx_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_count_o, rsp_err_o,
           tx_start_o, tx_data_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_count_i, cmd_wdata_i, rsp_ready_i,
           tx_ready_i, rx_data_i, new_rx_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_count_o, rsp_err_o,
           tx_start_o, tx_data_o
  );
endinterface

// File: rtl/cmd_issuer.sv
// cmd_issuer: serializes one host command per request onto the UART byte stream
// and collects the '0'/'1' response characters of state/output reads.
module cmd_issuer #(
  parameter int unsigned MAX_BITS       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic         clk,
  input logic         rstn,
  cmd_issuer_if.slave bus
);
  localparam int unsigned IDX_W  = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BYTE_W = 17;

  typedef enum logic [2:0] {
    IDLE, SEND_WAIT_RDY, SEND_START, SEND_WAIT_BUSY, RECV, RESP
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [15:0]         count_q, count_d;
  logic [MAX_BITS-1:0] wdata_q, wdata_d;
  logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [MAX_BITS-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]         rsp_count_q, rsp_count_d;
  logic                rsp_err_q, rsp_err_d;

  logic                has_count, has_payload, has_recv, rx_is_bit;
  logic [BYTE_W-1:0]   last_byte, pay_idx;
  logic [7:0]          cur_byte;

  function automatic logic op_known(input logic [7:0] op);
    return op inside {8'h72, 8'h65, 8'h66, 8'h70, 8'h73, 8'h67, 8'h69, 8'h6f};
  endfunction

  // Opcode classes of the latched command and the byte at the current stream index
  always_comb begin
    has_count   = op_q inside {8'h65, 8'h73, 8'h69, 8'h67, 8'h6f};
    has_payload = op_q inside {8'h73, 8'h69};
    has_recv    = op_q inside {8'h67, 8'h6f};
    last_byte   = has_payload ? (BYTE_W'(count_q) + BYTE_W'(2))
                              : (has_count ? BYTE_W'(2) : '0);
    pay_idx     = byte_idx_q - BYTE_W'(3);
    rx_is_bit   = (bus.rx_data_i == 8'h30) || (bus.rx_data_i == 8'h31);
    cur_byte    = 8'h30;
    case (byte_idx_q)
      BYTE_W'(0): cur_byte = op_q;
      BYTE_W'(1): cur_byte = count_q[15:8];
      BYTE_W'(2): cur_byte = count_q[7:0];
      default:    if (32'(pay_idx) < MAX_BITS && wdata_q[pay_idx[IDX_W-1:0]]) cur_byte = 8'h31;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    count_d     = count_q;
    wdata_d     = wdata_q;
    byte_idx_d  = byte_idx_q;
    tmr_d       = tmr_q;
    cmd_ready_d = cmd_ready_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_count_d = rsp_count_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_q) begin
          op_d        = bus.cmd_op_i;
          count_d     = bus.cmd_count_i;
          wdata_d     = bus.cmd_wdata_i;
          byte_idx_d  = '0;
          cmd_ready_d = 1'b0;
          rsp_data_d  = '0;
          rsp_count_d = '0;
          rsp_err_d   = 1'b0;
          if (op_known(bus.cmd_op_i)) begin
            state_d = SEND_WAIT_RDY;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      SEND_WAIT_RDY: begin
        if (bus.tx_ready_i) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          // Receive phase opens together with the last header start pulse
          if (has_recv && count_q != 16'd0 && byte_idx_q == BYTE_W'(2)) begin
            tmr_d   = '0;
            state_d = RECV;
          end else begin
            state_d = SEND_START;
          end
        end
      end
      SEND_START: state_d = SEND_WAIT_BUSY;
      SEND_WAIT_BUSY: begin
        if (!bus.tx_ready_i) begin
          if (byte_idx_q == last_byte) begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            state_d    = SEND_WAIT_RDY;
          end
        end
      end
      RECV: begin
        if (bus.new_rx_data_i) begin
          tmr_d = '0;
          if (!rx_is_bit) begin
            rsp_err_d = 1'b1;
          end else if (32'(rsp_count_q) < MAX_BITS) begin
            rsp_data_d[rsp_count_q[IDX_W-1:0]] = bus.rx_data_i[0];
          end
          rsp_count_d = (rsp_count_q == 16'hFFFF) ? 16'hFFFF : rsp_count_q + 16'd1;
          if (rsp_count_d == count_q) begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      op_q        <= '0;
      count_q     <= '0;
      wdata_q     <= '0;
      byte_idx_q  <= '0;
      tmr_q       <= '0;
      cmd_ready_q <= 1'b1;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      byte_idx_q  <= byte_idx_d;
      tmr_q       <= tmr_d;
      cmd_ready_q <= cmd_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_count_q <= rsp_count_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.tx_start_o  = tx_start_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_count_o = rsp_count_q;
  assign bus.rsp_err_o   = rsp_err_q;
endmodule
